// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule state type and GF(2^8) helpers
//
// Contents:
//   AES_KW, AES_NR      cipher key width and round count (AES-128 only)
//   ks_state_t          key-schedule FSM states
//   rcon()              round constant for rounds 1..10
//   rot_word()          RotWord: cyclic left rotate of a word by one byte
//   xtime/gf_mul/gf_inv GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
//   sbox_affine()       S-box affine transform applied after inversion

package aes_pkg;

    localparam int AES_KW = 128;
    localparam int AES_NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] value;
        case (round)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128.
    // Zero maps to zero naturally, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - 8-bit combinational AES forward S-box
//
// Ports:
//   data  in   byte to substitute
//   sub   out  S-box(data)
//
// Computed as inversion in GF(2^8) followed by the affine map rather than a
// 256-entry table, so the same cell serves SubWord here and the subbytes stage.

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    assign sub = sbox_affine(gf_inv(data));

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion, one round key per clock
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   anahtar    in   128-bit cipher key, byte 0 in [127:120]; sampled on accepted start
//   start      in   request expansion; accepted only while hazir=1
//   hazir      out  idle, ready to accept start
//   key        out  round key r at key[128*r +: 128], r = 0..10
//   rk_valid   out  bit r set once round key r has been written
//   finish     out  one-cycle pulse after round key 10 is written
//   key_valid  out  full schedule valid and held stable

module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KW-1:0]          anahtar,
    input  logic                   start,
    output logic                   hazir,
    output logic [KW*(NR+1)-1:0]   key,
    output logic [NR:0]            rk_valid,
    output logic                   finish,
    output logic                   key_valid
);

    ks_state_t              state_q, state_d;
    logic [3:0]             rc_q, rc_d;
    logic [KW*(NR+1)-1:0]   key_q, key_d;
    logic [NR:0]            rk_valid_q, rk_valid_d;
    logic                   finish_q, finish_d;
    logic                   key_valid_q, key_valid_d;
    logic                   hazir_q, hazir_d;

    logic [KW-1:0]          prev;
    logic [31:0]            w0, w1, w2, w3;
    logic [31:0]            rot;
    logic [31:0]            sub_word;
    logic [31:0]            t;
    logic [31:0]            n0, n1, n2, n3;
    logic [KW-1:0]          next_rk;

    // Previous round key selected with constant slices so that rc values
    // outside 1..NR (e.g. while idle) simply yield zero instead of an
    // out-of-range part select.
    always_comb begin
        prev = '0;
        for (int i = 1; i <= NR; i++) begin
            if (rc_q == 4'(i)) begin
                prev = key_q[(i-1)*KW +: KW];
            end
        end
    end

    assign w0  = prev[127:96];
    assign w1  = prev[95:64];
    assign w2  = prev[63:32];
    assign w3  = prev[31:0];
    assign rot = rot_word(w3);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .data (rot[31-8*g -: 8]),
            .sub  (sub_word[31-8*g -: 8])
        );
    end

    assign t       = sub_word ^ {rcon(rc_q), 24'h000000};
    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        key_d       = key_q;
        rk_valid_d  = rk_valid_q;
        finish_d    = 1'b0;
        key_valid_d = key_valid_q;
        hazir_d     = hazir_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Stale upper round keys are cleared so a partially
                    // rebuilt schedule never shows keys from the old cipher key.
                    key_d           = '0;
                    key_d[KW-1:0]   = anahtar;
                    rk_valid_d      = {{NR{1'b0}}, 1'b1};
                    key_valid_d     = 1'b0;
                    rc_d            = 4'd1;
                    hazir_d         = 1'b0;
                    state_d         = RUN;
                end
            end
            RUN: begin
                for (int i = 1; i <= NR; i++) begin
                    if (rc_q == 4'(i)) begin
                        key_d[i*KW +: KW] = next_rk;
                        rk_valid_d[i]     = 1'b1;
                    end
                end
                if (rc_q == 4'(NR)) begin
                    state_d     = IDLE;
                    finish_d    = 1'b1;
                    key_valid_d = 1'b1;
                    hazir_d     = 1'b1;
                    rc_d        = 4'd0;
                end else begin
                    rc_d = rc_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rc_q        <= 4'd0;
            key_q       <= '0;
            rk_valid_q  <= '0;
            finish_q    <= 1'b0;
            key_valid_q <= 1'b0;
            hazir_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            key_q       <= key_d;
            rk_valid_q  <= rk_valid_d;
            finish_q    <= finish_d;
            key_valid_q <= key_valid_d;
            hazir_q     <= hazir_d;
        end
    end

    assign hazir     = hazir_q;
    assign key       = key_q;
    assign rk_valid  = rk_valid_q;
    assign finish    = finish_q;
    assign key_valid = key_valid_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative AES-128 key expansion. It sits directly upstream of the round datapath in aes_engine and supplies the full 11-round-key schedule consumed by the add-round-key stage. It computes one 128-bit round key per clock, reusing a single SubWord/RotWord/Rcon path. It holds the finished schedule stable until the next accepted start.

Parameters:
NR, 10, number of rounds; round keys produced = NR+1. Only 10 (AES-128) is supported.
KW, 128, cipher key / round key width in bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
anahtar  input  128  cipher key; byte 0 = anahtar[127:120] (FIPS-197 order); sampled only when start is accepted
start  input  1  request expansion; accepted only when hazir=1
hazir  output  1  high in IDLE; block can accept start
key  output  1408  round key r at key[128*r +: 128], r=0..10; round 0 = cipher key
rk_valid  output  11  bit r set once round key r is written; streaming consumers may start early
finish  output  1  single-cycle pulse when round key 10 is written
key_valid  output  1  level; full schedule valid and stable

Behaviour:
- Reset (rst=0, async): state=IDLE, round counter=0, key=0, rk_valid=0, finish=0, key_valid=0, hazir=1 once released.
- States: IDLE, RUN. A 4-bit round counter rc runs 1..10.
- IDLE: if start=1 at an edge, load key[127:0] with anahtar, rk_valid=11'b1, key_valid=0, rc=1, go to RUN. Clear key[1407:128] on the same edge. hazir=0 from that edge.
- RUN, each edge:
  - Previous round key p = key[128*(rc-1) +: 128] is split into words w0..w3, with w0=p[127:96].
  - t = SubWord(RotWord(w3)) XOR {Rcon[rc],24'h0}.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
  - Write {n0,n1,n2,n3} to key[128*rc +: 128] and set rk_valid[rc].
  - If rc==10: go to IDLE, finish=1 for exactly the next cycle, key_valid=1. Otherwise rc=rc+1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency: start sampled at edge E0; round r written at edge E0+r (r=1..10); finish and key_valid high after E0+10.
- start while RUN: ignored; there is no queueing.
- anahtar changes during RUN: no effect; only the value latched at acceptance is used.
- start in the finish cycle: accepted, because state is already IDLE. At that edge finish drops, key_valid drops, and the new round 0 loads.
- key_valid stays 1 and key stays unchanged indefinitely until the next accepted start or reset.
- Reset asserted mid-RUN: immediate return to the reset values; the partial schedule is discarded and no finish pulse is issued.
- All outputs are registered. There is no combinational path from start or anahtar to any output.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_KW=128, AES_NR=10;
  - Rcon table function;
  - state enum (IDLE, RUN);
  - SubWord/RotWord helper functions, if the team packages S-box logic as functions.
- One sub-module: aes_sbox, an 8-bit combinational S-box. It is instantiated 4x for SubWord and is shared with the subbytes stage.

Test Plan:
- FIPS-197 A.1: anahtar=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle ->
  - key[255:128]=a0fafe1788542cb123a339392a6c7605;
  - key[1407:1280]=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - finish pulse exactly 10 edges after acceptance;
  - rk_valid bits rise one per cycle.
- All-zero key ->
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Held start and anahtar toggling during RUN -> schedule still matches the key latched at acceptance; hazir=0 throughout RUN; exactly one finish pulse.
- Back-to-back: start asserted in the finish cycle with a new key ->
  - new expansion begins;
  - key_valid drops;
  - rk_valid=11'b1 next cycle;
  - second schedule is correct.
- rst pulsed low at round 5 -> all outputs zero immediately; no finish; hazir=1 after release; a fresh start produces a correct schedule.
- Idle hold: after finish, 50 idle cycles with anahtar randomized -> key and key_valid unchanged.
